// File: rtl/multi_channel_data_loader.sv
// Round-robin drain of per-channel {key,value} pairs into single-word DRAM writes.
// Define MULTI_CHANNEL_DATA_LOADER_BOUNDS_CHECK_EN to drop keys above MAX_KEY.
module multi_channel_data_loader #(
   parameter int ADDRESS_WIDTH = 31,
   parameter logic [ADDRESS_WIDTH-1:0] DRAM_BASE_ADDR = ADDRESS_WIDTH'(31'h40000000),
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH = 4,
   parameter int KEY_SHIFT = 6,
   parameter logic [31:0] MAX_KEY = 32'h000FFFFF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH*2*DATA_WIDTH-1:0] ch_readdata,
   input  logic [NUM_CH-1:0]            ch_waitrequest,
   output logic [NUM_CH-1:0]            ch_read,
   output logic                         control_fixed_location,
   output logic [ADDRESS_WIDTH-1:0]     control_write_base,
   output logic [ADDRESS_WIDTH-1:0]     control_write_length,
   output logic                         control_go,
   input  logic                         control_done,
   output logic                         user_write_buffer,
   output logic [DATA_WIDTH-1:0]        user_buffer_input_data,
   input  logic                         user_buffer_full,
   output logic                         busy,
   output logic [31:0]                  write_count,
   output logic [31:0]                  drop_count
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [DATA_WIDTH-1:0] KEY_LIMIT = DATA_WIDTH'(MAX_KEY);
`ifdef MULTI_CHANNEL_DATA_LOADER_BOUNDS_CHECK_EN
   localparam logic BOUNDS_EN = 1'b1;
`else
   localparam logic BOUNDS_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE, WAIT_READ, CAPTURE, COMPUTE, WRITE, WAIT_DONE
   } state_t;

   state_t state, state_n;
   logic [CH_W-1:0] last_grant, grant_idx;
   logic grant_found;
   logic [DATA_WIDTH-1:0] key, value;
   logic drop;
   logic [ADDRESS_WIDTH-1:0] key_addr;

   assign control_fixed_location = 1'b0;
   assign busy = (state != IDLE);
   assign drop = BOUNDS_EN && (key > KEY_LIMIT);
   assign key_addr = ADDRESS_WIDTH'(key) << KEY_SHIFT;

   // Search starts just past the previous winner so every channel gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx = last_grant;
      for (int k = 1; k <= NUM_CH; k++) begin
         int idx;
         idx = (int'(last_grant) + k) % NUM_CH;
         if (!grant_found && !ch_waitrequest[idx]) begin
            grant_found = 1'b1;
            grant_idx = CH_W'(idx);
         end
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:      if (grant_found) state_n = WAIT_READ;
         WAIT_READ: state_n = CAPTURE;
         CAPTURE:   state_n = COMPUTE;
         COMPUTE:   state_n = drop ? IDLE : WRITE;
         WRITE:     if (!user_buffer_full) state_n = WAIT_DONE;
         WAIT_DONE: if (control_done) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= CH_W'(NUM_CH - 1);
         ch_read <= '0;
         key <= '0;
         value <= '0;
         control_write_base <= '0;
         control_write_length <= '0;
         control_go <= 1'b0;
         user_write_buffer <= 1'b0;
         user_buffer_input_data <= '0;
         write_count <= '0;
         drop_count <= '0;
      end else begin
         ch_read <= '0;
         control_go <= 1'b0;
         user_write_buffer <= 1'b0;
         if (state == IDLE && grant_found) begin
            ch_read <= NUM_CH'(1) << grant_idx;
            last_grant <= grant_idx;
         end
         if (state == CAPTURE) begin
            key <= ch_readdata[int'(last_grant)*2*DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH];
            value <= ch_readdata[int'(last_grant)*2*DATA_WIDTH +: DATA_WIDTH];
         end
         if (state == COMPUTE) begin
            if (drop) begin
               drop_count <= drop_count + 32'd1;
            end else begin
               control_write_base <= DRAM_BASE_ADDR + key_addr;
               control_write_length <= ADDRESS_WIDTH'(DATA_WIDTH / 8);
               control_go <= 1'b1;
            end
         end
         if (state == WRITE && !user_buffer_full) begin
            user_write_buffer <= 1'b1;
            user_buffer_input_data <= value;
         end
         if (state == WAIT_DONE && control_done)
            write_count <= write_count + 32'd1;
      end
   end

endmodule
